// File: rtl/disp_cmd_writer.sv
// disp_cmd_writer: producer end of the display command FIFO.
// Buffers host command bytes in a small queue and writes them one at a time to
// an external asynchronous FIFO with a timed setup / strobe / hold / settle cycle.
module disp_cmd_writer #(
    parameter int QDEPTH_LOG2   = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int PULSE_CYCLES  = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       nff_in,
    output logic [7:0] disp_cmd_out,
    output logic       disp_cmd_wr,
    output logic       busy
);

    localparam int QDEPTH = 1 << QDEPTH_LOG2;

    // Phase counter holds "cycles remaining minus one", so it only needs to
    // reach the longest phase length minus one.
    localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_B = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE   = QDEPTH_LOG2'(1);
    localparam logic [QDEPTH_LOG2:0]   COUNT_ONE = (QDEPTH_LOG2 + 1)'(1);

    logic [7:0]             mem [QDEPTH];
    logic [QDEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [QDEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [QDEPTH_LOG2:0]   count_q, count_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             out_q, out_d;
    logic                   wr_q, wr_d;
    logic                   sync1_q, nff_s_q;
    logic                   push, pop;

    // Queue is full exactly when the count reaches QDEPTH, i.e. its MSB is set.
    assign cmd_ready    = ~count_q[QDEPTH_LOG2];
    assign push         = cmd_valid & cmd_ready;
    assign busy         = (count_q != '0) || (state_q != S_IDLE);
    assign disp_cmd_out = out_q;
    assign disp_cmd_wr  = wr_q;

    // Two-flop synchroniser for the asynchronous full flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            nff_s_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let both flops sample pre-edge values, forming a true two-stage shift.
            sync1_q <= nff_in;
            nff_s_q <= sync1_q;
        end
    end

    // Queue storage write port.
    // NOTE: the storage array has no reset; reset empties the queue via the pointers and count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= cmd_data;
        end
    end

    // Write-cycle sequencer and queue pointer bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && nff_s_q) begin
                    pop     = 1'b1;
                    out_d   = mem[rptr_q];
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_STROBE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Strobe is decoded from the next state and then registered, so the
        // pin is driven straight from a flop and cannot glitch.
        wr_d = (state_d != S_STROBE);

        wptr_d  = push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d  = pop  ? (rptr_q + PTR_ONE) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    // State registers; reset raises the strobe at once and discards the queue.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            out_q   <= 8'h00;
            wr_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_disp_cmd_writer.sv
// tb_disp_cmd_writer: directed scenarios plus a randomized phase, checked
// every cycle against a timeline model of the FIFO write protocol.
module tb_disp_cmd_writer;

    localparam int QD     = 4;
    localparam int SETUP  = 1;
    localparam int PULSE  = 2;
    localparam int HOLD   = 1;
    localparam int SETTLE = 3;
    localparam int PERIOD = 1 + SETUP + PULSE + HOLD + SETTLE;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       nff_in;
    logic [7:0] disp_cmd_out;
    logic       disp_cmd_wr;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    disp_cmd_writer #(
        .QDEPTH_LOG2  (2),
        .SETUP_CYCLES (SETUP),
        .PULSE_CYCLES (PULSE),
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .nff_in      (nff_in),
        .disp_cmd_out(disp_cmd_out),
        .disp_cmd_wr (disp_cmd_wr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_ph counts cycles elapsed since a byte was loaded (0 = no write running).
    logic [7:0] mq[$];
    int         m_ph;
    logic [7:0] m_out;
    logic       m_s1, m_s2;

    always @(posedge clk or negedge nrst) begin
        int  sz;
        bit  psh;
        if (!nrst) begin
            mq.delete();
            m_ph  = 0;
            m_out = 8'h00;
            m_s1  = 1'b0;
            m_s2  = 1'b0;
        end else begin
            sz  = mq.size();
            psh = cmd_valid && (sz < QD);
            if (m_ph == 0) begin
                if (sz > 0 && m_s2) begin
                    m_out = mq.pop_front();
                    m_ph  = 1;
                end
            end else if (m_ph == PERIOD - 1) begin
                m_ph = 0;
            end else begin
                m_ph = m_ph + 1;
            end
            if (psh) mq.push_back(cmd_data);
            m_s2 = m_s1;
            m_s1 = nff_in;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        logic exp_wr;
        #1;
        exp_wr = !((m_ph >= 1 + SETUP) && (m_ph <= SETUP + PULSE));
        check("model_wr",    disp_cmd_wr,  exp_wr);
        check("model_out",   disp_cmd_out, m_out);
        check("model_ready", cmd_ready,    (mq.size() < QD));
        check("model_busy",  busy,         (mq.size() > 0) || (m_ph != 0));
    end

    // FIFO-side observer: captures each strobe falling edge.
    int         falls = 0;
    time        fall_t[$];
    logic [7:0] rx[$];

    always @(negedge disp_cmd_wr) begin
        if (nrst === 1'b1) begin
            falls++;
            fall_t.push_back($time);
            rx.push_back(disp_cmd_out);
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input logic [7:0] b);
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    task automatic wait_wr_low(input int max_cyc);
        int n = 0;
        while (disp_cmd_wr && n < max_cyc) begin
            step();
            n++;
        end
        check("wait_wr_low", disp_cmd_wr, 1'b0);
    endtask

    initial begin
        int  f0;
        int  idx;
        bit  rdy;
        bit  dropped;
        logic [7:0] v;

        nrst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        nff_in    = 1'b1;
        #1 nrst = 1'b0;

        // 1: reset values, then nothing happens with an empty queue
        #2;
        check("rst_wr",    disp_cmd_wr,  1'b1);
        check("rst_out",   disp_cmd_out, 8'h00);
        check("rst_ready", cmd_ready,    1'b1);
        check("rst_busy",  busy,         1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        repeat (6) step();
        check("idle_no_strobe", falls, 0);
        check("idle_busy", busy, 1'b0);

        // 2: single byte timing
        f0 = falls;
        @(negedge clk);
        cmd_data = 8'hA5; cmd_valid = 1'b1;
        step();                                   // edge N
        @(negedge clk) cmd_valid = 1'b0;
        step();                                   // N+1
        check("a5_out_n1", disp_cmd_out, 8'hA5);
        check("a5_wr_n1",  disp_cmd_wr,  1'b1);
        step(); check("a5_wr_n2", disp_cmd_wr, 1'b0);
        step(); check("a5_wr_n3", disp_cmd_wr, 1'b0);
        step(); check("a5_wr_n4", disp_cmd_wr, 1'b1);
        repeat (3) step();                        // N+7
        check("a5_busy_n7", busy, 1'b1);
        step();                                   // N+8
        check("a5_busy_n8", busy, 1'b0);
        check("a5_one_strobe", falls - f0, 1);

        // 3: hold valid with 01..06, queue fills, 8-cycle spacing
        f0 = falls; idx = 1; dropped = 0;
        while (idx <= 6) begin
            @(negedge clk);
            cmd_data  = 8'(idx);
            cmd_valid = 1'b1;
            rdy = cmd_ready;
            if (!rdy) dropped = 1;
            @(posedge clk);
            if (rdy) idx++;
        end
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle(100);
        check("burst_ready_dropped", dropped, 1'b1);
        check("burst_count", falls - f0, 6);
        for (int k = 0; k < 6; k++) begin
            if (f0 + k < rx.size()) check("burst_order", rx[f0 + k], 8'(k + 1));
        end
        for (int k = 1; k < 6; k++) begin
            if (f0 + k < fall_t.size())
                check("burst_spacing", 32'(fall_t[f0 + k] - fall_t[f0 + k - 1]), 32'(PERIOD * 10));
        end

        // 4: full flag holds off, release timing
        @(negedge clk) nff_in = 1'b0;
        repeat (3) step();
        f0 = falls;
        push_one(8'h3C);
        repeat (10) step();
        check("full_no_strobe", falls - f0, 0);
        check("full_busy", busy, 1'b1);
        @(negedge clk) nff_in = 1'b1;
        step();                                   // M
        step();                                   // M+1
        check("rel_out_m1", disp_cmd_out, 8'h06);
        step();                                   // M+2
        check("rel_out_m2", disp_cmd_out, 8'h3C);
        check("rel_wr_m2",  disp_cmd_wr,  1'b1);
        step();                                   // M+3
        check("rel_wr_m3",  disp_cmd_wr,  1'b0);
        wait_idle(40);

        // 5: full flag falls mid-strobe; current write completes, next waits
        f0 = falls;
        push_one(8'h11);
        push_one(8'h22);
        wait_wr_low(20);
        @(negedge clk) nff_in = 1'b0;
        repeat (20) step();
        check("midfull_count", falls - f0, 1);
        if (rx.size() > 0) check("midfull_byte", rx[rx.size() - 1], 8'h11);
        check("midfull_busy", busy, 1'b1);
        @(negedge clk) nff_in = 1'b1;
        wait_idle(40);
        check("midfull_resume", falls - f0, 2);
        if (rx.size() > 0) check("midfull_next", rx[rx.size() - 1], 8'h22);

        // 6: async reset during strobe with 3 bytes queued
        f0 = falls;
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_data = 8'hA1 + 8'(k);
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_wr_low(20);
        check("rst6_queued", busy, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check("rst6_wr",    disp_cmd_wr,  1'b1);
        check("rst6_out",   disp_cmd_out, 8'h00);
        check("rst6_ready", cmd_ready,    1'b1);
        check("rst6_busy",  busy,         1'b0);
        @(negedge clk) nrst = 1'b1;
        repeat (20) step();
        check("rst6_no_write", falls - f0, 1);
        check("rst6_idle", busy, 1'b0);

        // Randomized phase, checked by the per-cycle model comparison.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) != 0);
            v = 8'($urandom);
            cmd_data = ($urandom_range(0, 7) == 0) ? 8'h00 : v;
            if ($urandom_range(0, 15) == 0) nff_in = ~nff_in;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        nff_in    = 1'b1;
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
